// File: rtl/pixel_sensor_adc_model_pkg.sv
// rtl/pixel_sensor_adc_model_pkg.sv - shared pixel sensor configuration and ADC state encoding
package pixel_sensor_adc_model_pkg;

    localparam int PIXEL_BITS     = 8;
    localparam int PIXEL_ADC_BITS = PIXEL_BITS;

    typedef enum logic [2:0] {
        IDLE,
        EXPOSE,
        HOLD,
        CONVERT,
        DONE
    } pixel_adc_state_t;

endpackage

// File: rtl/pixel_sensor_adc_model_sat_accumulator.sv
// rtl/pixel_sensor_adc_model_sat_accumulator.sv - saturating accumulator with sticky saturation flag
module sat_accumulator
    import pixel_sensor_adc_model_pkg::*;
#(
    parameter int BITS = PIXEL_ADC_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            add_en,
    input  logic [BITS-1:0] addend,
    output logic [BITS-1:0] value,
    output logic            sat
);

    localparam logic [BITS-1:0] MAX = '1;

    logic [BITS:0]   sum;
    logic [BITS-1:0] clamped;

    // One extra bit of headroom detects the overflow, which then clamps to MAX.
    always_comb begin
        sum     = {1'b0, value} + {1'b0, addend};
        clamped = sum[BITS] ? MAX : sum[BITS-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (clear) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (add_en) begin
            value <= clamped;
            if (clamped == MAX) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_sensor_adc_model.sv
// rtl/pixel_sensor_adc_model.sv - one pixel: saturating exposure integrator and single-slope ADC
module pixel_sensor_adc_model
    import pixel_sensor_adc_model_pkg::*;
#(
    parameter int              BITS       = PIXEL_ADC_BITS,
    parameter logic [BITS-1:0] RESET_CODE = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            expose,
    input  logic            ramp,
    input  logic            erase,
    input  logic [BITS-1:0] light,
    output logic            cmp,
    output logic [BITS-1:0] code,
    output logic            code_valid,
    output logic            saturated,
    output logic            busy
);

    localparam logic [BITS-1:0] MAX = '1;
    localparam logic [BITS-1:0] ONE = BITS'(1);

    pixel_adc_state_t state, state_next;

    logic [BITS-1:0] charge;
    logic [BITS-1:0] ramp_cnt;
    logic [BITS-1:0] threshold;
    logic            charge_add;
    logic            cnt_clear;
    logic            cnt_add;
    logic            cnt_sat;
    logic            trip;

    sat_accumulator #(.BITS(BITS)) u_charge (
        .clk    (clk),
        .reset  (reset),
        .clear  (erase),
        .add_en (charge_add),
        .addend (light),
        .value  (charge),
        .sat    (saturated)
    );

    sat_accumulator #(.BITS(BITS)) u_ramp_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .add_en (cnt_add),
        .addend (ONE),
        .value  (ramp_cnt),
        .sat    (cnt_sat)
    );

    // Brighter pixels trip earlier: the ramp only has to cover the remaining headroom.
    assign threshold = MAX - charge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        charge_add = 1'b0;
        cnt_clear  = 1'b0;
        cnt_add    = 1'b0;
        trip       = 1'b0;
        if (erase) begin
            state_next = IDLE;
            cnt_clear  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (expose) begin
                        state_next = EXPOSE;
                        charge_add = 1'b1;
                    end
                end
                EXPOSE: begin
                    if (expose) begin
                        charge_add = 1'b1;
                    end else begin
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (expose) begin
                        state_next = EXPOSE;
                        charge_add = 1'b1;
                    end else if (ramp) begin
                        state_next = CONVERT;
                        cnt_clear  = 1'b1;
                    end
                end
                CONVERT: begin
                    if (ramp) begin
                        if (cnt_sat || (ramp_cnt >= threshold)) begin
                            trip       = 1'b1;
                            state_next = DONE;
                        end else begin
                            cnt_add = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp        <= 1'b0;
            code       <= RESET_CODE;
            code_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy <= (state_next == EXPOSE) || (state_next == CONVERT);
            if (erase) begin
                cmp        <= 1'b0;
                code       <= RESET_CODE;
                code_valid <= 1'b0;
            end else if (trip) begin
                cmp        <= 1'b1;
                code       <= ramp_cnt;
                code_valid <= 1'b1;
            end
        end
    end

endmodule
